// File: rtl/npc_ras_unit.sv
// npc_ras_unit -- next-PC unit with an optional circular return-address stack.
//
// Holds the architectural PC and picks the next fetch address from npc_op:
//   000 SEQ  pc+4
//   001 BR   br_taken ? pc+4+(sext(imm[15:0])<<2) : pc+4
//   010 J    {pc[W-1:28], imm, 2'b00}
//   011 JR   {rs_addr[W-1:2], 2'b00}
//   100 CALL J target, push pc+4
//   101 RET  pop top if RAS non-empty, else JR target
//   11x      treated as SEQ
//
// Build option: define NPC_RAS_EN to build the RAS. Without it CALL acts as J,
// RET acts as JR, ras_empty=1, ras_full=0 and RAS_DEPTH is unused.
//
// Ports:
//   clk        rising-edge clock
//   PcReSet    async active-high reset (pc=RESET_VEC, RAS cleared)
//   stall      hold pc and RAS
//   npc_op     operation code
//   br_taken   branch condition (BR only)
//   imm        jump index / branch offset in [15:0]
//   rs_addr    register-jump target
//   pc         current PC
//   pc_plus4   pc+4 (link value)
//   ras_empty  RAS count == 0
//   ras_full   RAS count == RAS_DEPTH
module npc_ras_unit #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] RESET_VEC = 32'h0040_0000,
  parameter int          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             PcReSet,
  input  logic             stall,
  input  logic [2:0]       npc_op,
  input  logic             br_taken,
  input  logic [25:0]      imm,
  input  logic [WIDTH-1:0] rs_addr,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_BR   = 3'b001;
  localparam logic [2:0] OP_J    = 3'b010;
  localparam logic [2:0] OP_JR   = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);

  logic [WIDTH-1:0] br_off, br_tgt, j_tgt, jr_tgt, npc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_hit;

  assign pc_plus4 = pc + WIDTH'(4);
  assign br_off   = {{(WIDTH-18){imm[15]}}, imm[15:0], 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign j_tgt    = {pc[WIDTH-1:28], imm, 2'b00};
  assign jr_tgt   = {rs_addr[WIDTH-1:2], 2'b00};

`ifdef NPC_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]                   wp, wp_dec;
  logic [CW-1:0]                   cnt;
  logic                            push;

  // wp points at the next free slot, so the top lives one below it
  assign wp_dec    = wp - AW'(1);
  assign ras_top   = mem[wp_dec];
  assign ras_empty = (cnt == '0);
  assign ras_full  = (cnt == CNT_MAX);
  assign push      = (npc_op == OP_CALL);
  assign ras_hit   = (npc_op == OP_RET) && !ras_empty;

  always_ff @(posedge clk or posedge PcReSet) begin
    if (PcReSet) begin
      mem <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (!stall) begin
      if (push) begin
        // full push overwrites the oldest slot: wp has wrapped onto it
        mem[wp] <= pc_plus4;
        wp      <= wp + AW'(1);
        if (!ras_full) cnt <= cnt + CW'(1);
      end else if (ras_hit) begin
        wp  <= wp_dec;
        cnt <= cnt - CW'(1);
      end
    end
  end
`else
  assign ras_top   = '0;
  assign ras_hit   = 1'b0;
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
`endif

  always_comb begin
    npc = pc_plus4;
    case (npc_op)
      OP_SEQ:  npc = pc_plus4;
      OP_BR:   npc = br_taken ? br_tgt : pc_plus4;
      OP_J:    npc = j_tgt;
      OP_JR:   npc = jr_tgt;
      OP_CALL: npc = j_tgt;
      OP_RET:  npc = ras_hit ? ras_top : jr_tgt;
      default: npc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge PcReSet) begin
    if (PcReSet)     pc <= RST_PC;
    else if (!stall) pc <= npc;
  end

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed bench for npc_ras_unit. Expectations for RET/ras_* depend on
// whether NPC_RAS_EN is defined for the build.
module tb_npc_ras_unit;
  logic        clk = 1'b0;
  logic        PcReSet = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  npc_op = 3'b000;
  logic        br_taken = 1'b0;
  logic [25:0] imm = '0;
  logic [31:0] rs_addr = '0;
  logic [31:0] pc, pc_plus4;
  logic        ras_empty, ras_full;

  int n_run = 0;
  int n_fail = 0;

`ifdef NPC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  npc_ras_unit #(.WIDTH(32), .RESET_VEC(32'h0040_0000), .RAS_DEPTH(4)) dut (
    .clk(clk), .PcReSet(PcReSet), .stall(stall), .npc_op(npc_op),
    .br_taken(br_taken), .imm(imm), .rs_addr(rs_addr), .pc(pc),
    .pc_plus4(pc_plus4), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive one cycle's inputs, clock it, sample 1 time unit after the edge
  task automatic step(input logic [2:0] op, input logic bt, input logic [25:0] im,
                      input logic [31:0] rs, input logic st);
    npc_op = op; br_taken = bt; imm = im; rs_addr = rs; stall = st;
    @(posedge clk); #1;
  endtask

  task automatic jr(input logic [31:0] rs);
    step(3'b011, 1'b0, '0, rs, 1'b0);
  endtask

  logic [31:0] links [5];
  logic [31:0] tgt, cur;

  initial begin
    // async reset between edges
    #2 PcReSet = 1'b1;
    #1;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_pc4", pc_plus4, 32'h0040_0004);
    chk("rst_empty", {31'b0, ras_empty}, 32'd1);
    chk("rst_full", {31'b0, ras_full}, 32'd0);
    @(negedge clk); PcReSet = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      step(3'b000, 1'b0, '0, '0, 1'b0);
      chk("seq", pc, 32'h0040_0000 + 32'(i * 4));
    end

    // branches at 0x00400008 with offset -2 words
    jr(32'h0040_0008);
    step(3'b001, 1'b1, 26'h000FFFE, '0, 1'b0);
    chk("br_taken", pc, 32'h0040_0004);
    jr(32'h0040_0008);
    step(3'b001, 1'b0, 26'h000FFFE, '0, 1'b0);
    chk("br_not", pc, 32'h0040_000C);
    // forward branch, large positive offset
    step(3'b001, 1'b1, 26'h0007FFF, '0, 1'b0);
    chk("br_fwd", pc, 32'h0040_000C + 32'h4 + 32'h0001_FFFC);

    // wrap from all-ones
    jr(32'hFFFF_FFFC);
    chk("jr_top", pc, 32'hFFFF_FFFC);
    step(3'b000, 1'b0, '0, '0, 1'b0);
    chk("seq_wrap", pc, 32'h0000_0000);

    jr(32'h9000_0000);
    step(3'b010, 1'b0, 26'h0000010, '0, 1'b0);
    chk("j_region", pc, 32'h9000_0040);
    jr(32'h0040_0123);
    chk("jr_align", pc, 32'h0040_0120);
    step(3'b110, 1'b1, 26'h3FFFFFF, 32'h1234_5678, 1'b0);
    chk("rsv110", pc, 32'h0040_0124);
    step(3'b111, 1'b1, 26'h3FFFFFF, 32'h1234_5678, 1'b0);
    chk("rsv111", pc, 32'h0040_0128);

    // two calls then returns
    jr(32'h0040_0000);
    step(3'b100, 1'b0, 26'h0100040, '0, 1'b0);
    chk("call1", pc, 32'h0040_0100);
    step(3'b100, 1'b0, 26'h0100080, '0, 1'b0);
    chk("call2", pc, 32'h0040_0200);
    chk("call_empty", {31'b0, ras_empty}, RAS ? 32'd0 : 32'd1);
    step(3'b101, 1'b0, '0, 32'h0040_0300, 1'b0);
    chk("ret1", pc, RAS ? 32'h0040_0104 : 32'h0040_0300);
    step(3'b101, 1'b0, '0, 32'h0040_0300, 1'b0);
    chk("ret2", pc, RAS ? 32'h0040_0004 : 32'h0040_0300);
    chk("ret2_empty", {31'b0, ras_empty}, 32'd1);
    step(3'b101, 1'b0, '0, 32'h0040_0200, 1'b0);
    chk("ret_empty_jr", pc, 32'h0040_0200);

    // five calls into a depth-4 stack
    jr(32'h0040_0000);
    cur = 32'h0040_0000;
    for (int i = 0; i < 5; i++) begin
      tgt = 32'h0040_1000 + 32'(i * 32'h100);
      links[i] = cur + 32'd4;
      step(3'b100, 1'b0, tgt[27:2], '0, 1'b0);
      chk("call_n", pc, tgt);
      cur = tgt;
    end
    chk("full5", {31'b0, ras_full}, RAS ? 32'd1 : 32'd0);
    for (int i = 4; i >= 1; i--) begin
      step(3'b101, 1'b0, '0, 32'h0040_0800, 1'b0);
      chk("ret_lifo", pc, RAS ? links[i] : 32'h0040_0800);
      chk("ret_notfull", {31'b0, ras_full}, 32'd0);
    end
    chk("lifo_empty", {31'b0, ras_empty}, 32'd1);
    step(3'b101, 1'b0, '0, 32'h0040_0800, 1'b0);
    chk("oldest_lost", pc, 32'h0040_0800);

    // stall holds pc and RAS
    jr(32'h0040_0000);
    step(3'b100, 1'b0, 26'h0100400, '0, 1'b0);
    chk("call_pre", pc, 32'h0040_1000);
    step(3'b100, 1'b0, 26'h0100080, '0, 1'b1);
    chk("stall_pc", pc, 32'h0040_1000);
    step(3'b000, 1'b0, '0, '0, 1'b1);
    chk("stall_seq", pc, 32'h0040_1000);
    step(3'b101, 1'b0, '0, 32'h0040_0900, 1'b0);
    chk("stall_ret", pc, RAS ? 32'h0040_0004 : 32'h0040_0900);
    chk("stall_empty", {31'b0, ras_empty}, 32'd1);

    // reset after a call clears the stack
    step(3'b100, 1'b0, 26'h0100400, '0, 1'b0);
    #2 PcReSet = 1'b1;
    #1;
    chk("rst2_pc", pc, 32'h0040_0000);
    chk("rst2_empty", {31'b0, ras_empty}, 32'd1);
    @(negedge clk); PcReSet = 1'b0;
    step(3'b100, 1'b0, 26'h0100400, '0, 1'b0);
    chk("call_after_rst", pc, 32'h0040_1000);
    step(3'b101, 1'b0, '0, 32'h0040_0040, 1'b0);
    chk("ret_after_rst", pc, RAS ? 32'h0040_0004 : 32'h0040_0040);
    chk("final_empty", {31'b0, ras_empty}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
